// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end.
//   NOP_INSTR      : canonical bubble instruction (addi x0,x0,0)
//   fetch_state_t  : debug view of the fetch unit's occupancy
//   fetch_state()  : maps the resp/hold valid flags onto fetch_state_t
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_EMPTY = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_HOLD  = 2'd2
  } fetch_state_t;

  function automatic fetch_state_t fetch_state(input logic resp_valid,
                                               input logic hold_valid);
    if (!resp_valid)     return FETCH_EMPTY;
    else if (hold_valid) return FETCH_HOLD;
    else                 return FETCH_RUN;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a synchronous 1-cycle-latency
// instruction memory and presents the pc / instr / pc+4 triple to IF/ID.
// A one-entry hold buffer keeps the output stable under stall; a redirect
// kills the current output and restarts fetch at the (word-aligned) target.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_f           downstream not accepting the current output
//   redirect_valid    taken branch/jump from EX
//   redirect_target   restart address
//   imem_req          imem read enable this cycle
//   imem_addr         imem read address
//   imem_rdata        data for the address requested in the previous cycle
//   pc_f              PC of the presented instruction
//   instr_f           presented instruction (NOP_INSTR when not valid)
//   pc_plus4_f        pc_f + 4 (wraps)
//   valid_f           presented instruction is real
//   misalign_err      sticky: some redirect target had bits [1:0] != 0
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(riscv_pkg::NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] instr_f,
  output logic [WIDTH-1:0] pc_plus4_f,
  output logic             valid_f,
  output logic             misalign_err
);

  logic [WIDTH-1:0] req_pc;
  logic [WIDTH-1:0] resp_pc;
  logic             resp_valid;
  logic [WIDTH-1:0] hold_instr;
  logic             hold_valid;
  logic [WIDTH-1:0] target_al;
  logic             hold_fill;
  fetch_state_t     state;

  assign state     = fetch_state(resp_valid, hold_valid);
  assign target_al = {redirect_target[WIDTH-1:2], 2'b00};

  // RUN -> HOLD: capture the memory output before it is lost, since the
  // memory is not re-read while stalled.
  assign hold_fill = !rst && !redirect_valid && stall_f && (state == FETCH_RUN);

  // Request side: a redirect always issues, even when stalled.
  assign imem_req  = !rst && (redirect_valid || !stall_f);
  assign imem_addr = redirect_valid ? target_al : req_pc;

  // Presentation side: the redirect kills whatever is currently shown.
  assign valid_f    = (state != FETCH_EMPTY) && !redirect_valid;
  assign instr_f    = !valid_f ? NOP_INSTR
                    : ((state == FETCH_HOLD) ? hold_instr : imem_rdata);
  assign pc_f       = resp_pc;
  assign pc_plus4_f = resp_pc + WIDTH'(4);

  // Fetch control: request/response PCs and occupancy flags
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc       <= RESET_PC;
      resp_pc      <= RESET_PC;
      resp_valid   <= 1'b0;
      hold_valid   <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      req_pc       <= target_al + WIDTH'(4);
      resp_pc      <= target_al;
      resp_valid   <= 1'b1;
      hold_valid   <= 1'b0;
      if (redirect_target[1:0] != 2'b00) misalign_err <= 1'b1;
    end else if (!stall_f) begin
      req_pc     <= req_pc + WIDTH'(4);
      resp_pc    <= req_pc;
      resp_valid <= 1'b1;
      hold_valid <= 1'b0;
    end else if (hold_fill) begin
      hold_valid <= 1'b1;
    end
  end

  // Hold buffer data: only meaningful while hold_valid is set
  always_ff @(posedge clk) begin
    if (hold_fill) hold_instr <= imem_rdata;
  end

endmodule
